// File: rtl/std_lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to a std_lfsr_galois word stream,
// then predicts each word, reporting lock state and counting corrupted words.
module std_lfsr_checker #(
  parameter int              SIZE       = 8,
  parameter logic [SIZE-1:0] TAPS       = '0,  // '0 selects the std_lfsr_galois table entry
  parameter int              LOCK_CNT   = 4,
  parameter int              UNLOCK_CNT = 4,
  parameter int              CNTW       = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [SIZE-1:0] i_val,
  input  logic            i_clear,
  output logic            o_locked,
  output logic            o_err,
  output logic [CNTW-1:0] o_err_cnt,
  output logic [SIZE-1:0] o_expect
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SYNC   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  function automatic logic [63:0] tap_bit(input int x);
    return (x == 0) ? 64'd0 : (64'd1 << (x - 1));
  endfunction

  function automatic logic [63:0] taps4(input int a, input int b, input int c, input int d);
    return tap_bit(a) | tap_bit(b) | tap_bit(c) | tap_bit(d);
  endfunction

  // Maximal-length polynomial exponents shared with std_lfsr_galois.
  function automatic logic [SIZE-1:0] galois_taps(input int n);
    logic [63:0] t;
    case (n)
      2:  t = taps4(2, 1, 0, 0);    3:  t = taps4(3, 2, 0, 0);
      4:  t = taps4(4, 3, 0, 0);    5:  t = taps4(5, 3, 0, 0);
      6:  t = taps4(6, 5, 0, 0);    7:  t = taps4(7, 6, 0, 0);
      8:  t = taps4(8, 6, 5, 4);    9:  t = taps4(9, 5, 0, 0);
      10: t = taps4(10, 7, 0, 0);   11: t = taps4(11, 9, 0, 0);
      12: t = taps4(12, 6, 4, 1);   13: t = taps4(13, 4, 3, 1);
      14: t = taps4(14, 5, 3, 1);   15: t = taps4(15, 14, 0, 0);
      16: t = taps4(16, 15, 13, 4); 17: t = taps4(17, 14, 0, 0);
      18: t = taps4(18, 11, 0, 0);  19: t = taps4(19, 6, 2, 1);
      20: t = taps4(20, 17, 0, 0);  21: t = taps4(21, 19, 0, 0);
      22: t = taps4(22, 21, 0, 0);  23: t = taps4(23, 18, 0, 0);
      24: t = taps4(24, 23, 22, 17); 25: t = taps4(25, 22, 0, 0);
      26: t = taps4(26, 6, 2, 1);   27: t = taps4(27, 5, 2, 1);
      28: t = taps4(28, 25, 0, 0);  29: t = taps4(29, 27, 0, 0);
      30: t = taps4(30, 6, 4, 1);   31: t = taps4(31, 28, 0, 0);
      32: t = taps4(32, 22, 2, 1);  33: t = taps4(33, 20, 0, 0);
      34: t = taps4(34, 27, 2, 1);  35: t = taps4(35, 33, 0, 0);
      36: t = taps4(36, 25, 0, 0);  37: t = taps4(37, 5, 4, 3) | taps4(2, 1, 0, 0);
      38: t = taps4(38, 6, 5, 1);   39: t = taps4(39, 35, 0, 0);
      40: t = taps4(40, 38, 21, 19); 41: t = taps4(41, 38, 0, 0);
      42: t = taps4(42, 41, 20, 19); 43: t = taps4(43, 42, 38, 37);
      44: t = taps4(44, 43, 18, 17); 45: t = taps4(45, 44, 42, 41);
      46: t = taps4(46, 45, 26, 25); 47: t = taps4(47, 42, 0, 0);
      48: t = taps4(48, 47, 21, 20); 49: t = taps4(49, 40, 0, 0);
      50: t = taps4(50, 49, 24, 23); 51: t = taps4(51, 50, 36, 35);
      52: t = taps4(52, 49, 0, 0);  53: t = taps4(53, 52, 38, 37);
      54: t = taps4(54, 53, 18, 17); 55: t = taps4(55, 31, 0, 0);
      56: t = taps4(56, 55, 35, 34); 57: t = taps4(57, 50, 0, 0);
      58: t = taps4(58, 39, 0, 0);  59: t = taps4(59, 58, 38, 37);
      60: t = taps4(60, 59, 0, 0);  61: t = taps4(61, 60, 46, 45);
      62: t = taps4(62, 61, 6, 5);  63: t = taps4(63, 62, 0, 0);
      64: t = taps4(64, 63, 61, 60);
      default: t = '0;
    endcase
    return t[SIZE-1:0];
  endfunction

  localparam logic [SIZE-1:0] W_TAPS = (TAPS != '0) ? TAPS : galois_taps(SIZE);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int NW = $clog2(UNLOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_CNT - 1);
  localparam logic [NW-1:0] UNLOCK_LAST = NW'(UNLOCK_CNT - 1);

  function automatic logic [SIZE-1:0] step(input logic [SIZE-1:0] v);
    return {1'b0, v[SIZE-1:1]} ^ ({SIZE{v[0]}} & W_TAPS);
  endfunction

  logic [1:0]      r_state;
  logic            r_locked;
  logic            r_err;
  logic [CNTW-1:0] r_err_cnt;
  logic [SIZE-1:0] r_expect;
  logic [MW-1:0]   r_match;
  logic [NW-1:0]   r_miss;

  logic w_hit;
  assign w_hit = (i_val == r_expect);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_expect  <= '0;
      r_match   <= '0;
      r_miss    <= '0;
    end else begin
      r_err <= 1'b0;
      if (i_clear) r_err_cnt <= '0;
      if (i_en) begin
        case (r_state)
          S_IDLE: begin
            if (i_val != '0) begin
              r_expect <= step(i_val);
              r_match  <= '0;
              r_state  <= S_SYNC;
            end
          end
          S_SYNC: begin
            if (w_hit) begin
              r_expect <= step(i_val);
              if (r_match == LOCK_LAST) begin
                r_state  <= S_LOCKED;
                r_locked <= 1'b1;
                r_miss   <= '0;
              end else begin
                r_match <= r_match + MW'(1);
              end
            end else if (i_val != '0) begin
              r_expect <= step(i_val);
              r_match  <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_LOCKED: begin
            if (w_hit) begin
              r_expect <= step(r_expect);
              r_miss   <= '0;
            end else begin
              r_err <= 1'b1;
              // Clear takes priority, so the increment is suppressed rather than overridden.
              if (!i_clear && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNTW'(1);
              if (r_miss == UNLOCK_LAST) begin
                r_state  <= S_SYNC;
                r_locked <= 1'b0;
                r_expect <= step(i_val);
                r_match  <= '0;
              end else begin
                r_expect <= step(r_expect);
                r_miss   <= r_miss + NW'(1);
              end
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_locked  = r_locked;
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;
  assign o_expect  = r_expect;

endmodule

// File: tb/tb_std_lfsr_checker.sv
// Bench for std_lfsr_checker: vector table, directed corner sequences, a randomized
// stream against a reference model, and gapped streams at several LFSR widths.
module tb_std_lfsr_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr;
  logic [7:0] val;
  logic       a_locked, a_err, b_locked, b_err;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;
  logic [7:0]  a_exp, b_exp;

  std_lfsr_checker #(.SIZE(8), .LOCK_CNT(4), .UNLOCK_CNT(4), .CNTW(16)) u_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_val(val), .i_clear(clr),
    .o_locked(a_locked), .o_err(a_err), .o_err_cnt(a_cnt), .o_expect(a_exp));

  std_lfsr_checker #(.SIZE(8), .CNTW(4)) u_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_val(val), .i_clear(clr),
    .o_locked(b_locked), .o_err(b_err), .o_err_cnt(b_cnt), .o_expect(b_exp));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] nxt(input logic [63:0] v, input logic [63:0] t);
    return (v >> 1) ^ (v[0] ? t : 64'd0);
  endfunction

  function automatic logic [63:0] tap_of(input int s);
    case (s)
      2: return 64'h3;
      3: return 64'h6;
      5: return 64'h14;
      8: return 64'hB8;
      9: return 64'h110;
      12: return 64'h829;
      default: return 64'h0;
    endcase
  endfunction

  // Reference model of the checker for the 8-bit streams (LOCK_CNT=UNLOCK_CNT=4).
  localparam int M_IDLE = 0, M_SYNC = 1, M_LOCK = 2;
  int         m_st, m_match, m_miss, m_cnt;
  logic [7:0] m_exp;
  logic       m_err;

  task automatic model_reset();
    m_st = M_IDLE; m_match = 0; m_miss = 0; m_cnt = 0; m_exp = '0; m_err = 1'b0;
  endtask

  task automatic model(input logic e, input logic [7:0] v, input logic c);
    m_err = 1'b0;
    if (e) begin
      if (m_st == M_LOCK) begin
        if (v == m_exp) begin
          m_miss = 0;
          m_exp  = 8'(nxt(m_exp, 64'hB8));
        end else begin
          m_err = 1'b1; m_cnt++; m_miss++;
          if (m_miss == 4) begin
            m_st = M_SYNC; m_match = 0; m_exp = 8'(nxt(v, 64'hB8));
          end else m_exp = 8'(nxt(m_exp, 64'hB8));
        end
      end else if (m_st == M_SYNC && v == m_exp) begin
        m_exp = 8'(nxt(v, 64'hB8)); m_match++;
        if (m_match == 4) begin m_st = M_LOCK; m_miss = 0; end
      end else if (v != 8'd0) begin
        m_st = M_SYNC; m_match = 0; m_exp = 8'(nxt(v, 64'hB8));
      end else m_st = M_IDLE;
    end
    if (c) m_cnt = 0;
  endtask

  task automatic beat(input logic e, input logic [7:0] v, input logic c);
    en = e; val = v; clr = c;
    @(posedge clk); #1;
    model(e, v, c);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; val = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        e;
    logic [7:0]  v;
    logic        c;
    logic        lk;
    logic        er;
    logic [15:0] cnt;
    logic [7:0]  ex;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] gg[0:319];
  logic [7:0] hh[0:12];

  // Gapped streams at several widths, each with its own checker instance.
  localparam int NSZ = 5;
  localparam int SZL[NSZ] = '{2, 3, 5, 9, 12};
  int sz_done = 0;

  for (genvar gi = 0; gi < NSZ; gi++) begin : g_sz
    localparam int S = SZL[gi];
    logic         rs, en_s, lk, er;
    logic [S-1:0] v, ex;
    logic [15:0]  cn;

    std_lfsr_checker #(.SIZE(S)) u_dut (
      .i_clk(clk), .i_rst(rs), .i_en(en_s), .i_val(v), .i_clear(1'b0),
      .o_locked(lk), .o_err(er), .o_err_cnt(cn), .o_expect(ex));

    initial begin
      logic [63:0] t, cur, held;
      int nvalid, period;
      t = tap_of(S);
      period = (1 << S) - 1;
      rs = 1'b1; en_s = 1'b0; v = '0;
      @(posedge clk); #1;
      rs = 1'b0;
      cur = 64'($urandom_range(period, 1));
      held = '0;
      nvalid = 0;
      while (nvalid < 2 * period) begin
        en_s = 1'($urandom_range(1, 0));
        v = en_s ? S'(cur) : S'($urandom);
        @(posedge clk); #1;
        if (en_s) begin
          held = nxt(cur, t);
          cur = held;
          nvalid++;
        end
        chk($sformatf("sz%0d_lock", S), 64'(lk), 64'(nvalid >= 5));
        chk($sformatf("sz%0d_expect", S), 64'(ex), held);
        chk($sformatf("sz%0d_err", S), 64'(er), 64'd0);
        chk($sformatf("sz%0d_cnt", S), 64'(cn), 64'd0);
      end
      sz_done++;
    end
  end

  initial begin
    logic [7:0] cur, v;
    logic       e, c;
    int         r, j;

    gg[0] = 8'd1;
    for (int k = 1; k < 320; k++) gg[k] = 8'(nxt(gg[k-1], 64'hB8));
    hh[0] = 8'h5A;
    for (int k = 0; k < 77; k++) hh[0] = 8'(nxt(hh[0], 64'hB8));
    if (hh[0] == gg[300]) hh[0] = 8'(nxt(hh[0], 64'hB8));
    for (int k = 1; k < 13; k++) hh[k] = 8'(nxt(hh[k-1], 64'hB8));

    // Clean lock, one corrupted word at beat 150, periodic gaps.
    for (int k = 0; k < 300; k++) begin
      if (k > 0 && k % 37 == 0)
        tbl.push_back('{1'b0, 8'hC3, 1'b0, 1'(k - 1 >= 4), 1'b0, 16'(k - 1 >= 150), gg[k]});
      tbl.push_back('{1'b1, gg[k] ^ 8'(k == 150), 1'b0, 1'(k >= 4), 1'(k == 150),
                      16'(k >= 150), gg[k+1]});
    end
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'd0, gg[300]});
    // Stream switched to a different phase: 4 misses unlock, 4 matches relock.
    for (int i = 0; i < 12; i++)
      tbl.push_back('{1'b1, hh[i], 1'b0, 1'(i < 3 || i >= 7), 1'(i < 4),
                      16'(i < 4 ? i + 1 : 4), (i < 3) ? gg[301+i] : hh[i+1]});

    do_reset();
    chk("rst_locked", 64'(a_locked), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_expect", 64'(a_exp), 64'd0);
    chk("rst_b_cnt", 64'(b_cnt), 64'd0);

    foreach (tbl[i]) begin
      beat(tbl[i].e, tbl[i].v, tbl[i].c);
      chk($sformatf("tbl%0d_lock", i), 64'(a_locked), 64'(tbl[i].lk));
      chk($sformatf("tbl%0d_err", i), 64'(a_err), 64'(tbl[i].er));
      chk($sformatf("tbl%0d_cnt", i), 64'(a_cnt), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_expect", i), 64'(a_exp), 64'(tbl[i].ex));
      chk($sformatf("tbl%0d_b_cnt", i), 64'(b_cnt), 64'(tbl[i].cnt[3:0]));
      chk($sformatf("tbl%0d_b_lock", i), 64'(b_locked), 64'(tbl[i].lk));
    end

    // All-zero stream never leaves IDLE.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      beat(1'b1, 8'h00, 1'b0);
      chk("zero_lock", 64'(a_locked), 64'd0);
      chk("zero_cnt", 64'(a_cnt), 64'd0);
      chk("zero_expect", 64'(a_exp), 64'd0);
    end

    // Isolated errors: saturation in the 4-bit counter, clear priority, reset while locked.
    do_reset();
    for (int k = 0; k < 5; k++) beat(1'b1, gg[k], 1'b0);
    chk("sat_locked", 64'(a_locked), 64'd1);
    j = 5;
    for (int e2 = 0; e2 < 20; e2++) begin
      beat(1'b1, gg[j] ^ 8'h01, 1'b0); j++;
      chk("sat_err", 64'(a_err), 64'd1);
      chk("sat_a_cnt", 64'(a_cnt), 64'(e2 + 1));
      chk("sat_b_cnt", 64'(b_cnt), 64'(e2 + 1 > 15 ? 15 : e2 + 1));
      beat(1'b1, gg[j], 1'b0); j++;
      chk("sat_clean_err", 64'(a_err), 64'd0);
      chk("sat_lock", 64'(b_locked), 64'd1);
    end
    beat(1'b1, gg[j] ^ 8'h01, 1'b1); j++;
    chk("clr_a_cnt", 64'(a_cnt), 64'd0);
    chk("clr_b_cnt", 64'(b_cnt), 64'd0);
    chk("clr_err", 64'(a_err), 64'd1);
    rst = 1'b1; en = 1'b1; val = gg[j];
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstl_locked", 64'(a_locked), 64'd0);
    chk("rstl_err", 64'(a_err), 64'd0);
    chk("rstl_cnt", 64'(a_cnt), 64'd0);
    chk("rstl_expect", 64'(a_exp), 64'd0);
    chk("rstl_b_locked", 64'(b_locked), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      beat(1'b1, gg[j+k], 1'b0);
      chk("relock", 64'(a_locked), 64'(k == 5));
    end

    // Randomized stream with gaps, corruptions, phase jumps, zero words and clears.
    do_reset();
    cur = 8'($urandom_range(255, 1));
    for (int k = 0; k < 3000; k++) begin
      e = 1'(($urandom % 4) != 0);
      c = 1'(($urandom % 50) == 0);
      r = int'($urandom % 200);
      if (r < 2) cur = 8'($urandom_range(255, 1));
      v = (r >= 2 && r < 12) ? (cur ^ 8'($urandom_range(255, 1))) : ((r == 12) ? 8'h00 : cur);
      if (!e) v = 8'($urandom);
      beat(e, v, c);
      if (e) cur = 8'(nxt(cur, 64'hB8));
      chk("rnd_lock", 64'(a_locked), 64'(m_st == M_LOCK));
      chk("rnd_err", 64'(a_err), 64'(m_err));
      chk("rnd_expect", 64'(a_exp), 64'(m_exp));
      chk("rnd_a_cnt", 64'(a_cnt), 64'(m_cnt > 65535 ? 65535 : m_cnt));
      chk("rnd_b_cnt", 64'(b_cnt), 64'(m_cnt > 15 ? 15 : m_cnt));
      chk("rnd_b_err", 64'(b_err), 64'(m_err));
      chk("rnd_b_expect", 64'(b_exp), 64'(m_exp));
    end

    for (int w = 0; w < 40000 && sz_done < NSZ; w++) @(posedge clk);
    chk("sz_streams_done", 64'(sz_done), 64'(NSZ));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
